csa_resolve: RTL and testbench
==============================

# csa_resolve

Multi-cycle carry-propagate converter that turns a carry-save pair (carry vector plus sum vector) back into a plain binary word. It is the consumer end of the CSA compressor chain in the Montgomery multiplier datapath: after the CSA stages finish, this block resolves the redundant result once per operation. It adds CHUNK bits per cycle with a registered carry to bound the carry chain. An optional final conditional subtraction of the modulus is available.

## Interface
- WIDTH, 256: width of the sum vector; the carry vector is WIDTH+1 bits.
- CHUNK, 64: bits resolved per cycle. WIDTH % CHUNK == 0 is required. NCH = WIDTH/CHUNK.

- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- cin_vec  in  WIDTH+1  carry vector; bit 0 is ignored and treated as 0.
- s_vec  in  WIDTH  sum vector.
- mod_p  in  WIDTH  modulus; sampled with the operands. Ignored without the macro.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- result  out  WIDTH+2  resolved binary value.
- reduced  out  1  1 = the modulus was subtracted. Constant 0 without the macro.

## Operation
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE) & ~rst. It is combinational and is 0 in RUN and DONE.
- IDLE→RUN on in_valid & in_ready:
  - Register cin_vec (with bit 0 forced to 0), s_vec and mod_p.
  - Clear the carry and borrow registers.
  - Set the chunk index k = 0.
- RUN, each cycle:
  - Compute R[k] = cin[k*CHUNK +: CHUNK] + s[k*CHUNK +: CHUNK] + carry.
  - Write R[k] into the result register and update carry.
  - Increment k.
- After chunk NCH-1, the top two bits are {0,cin_vec[WIDTH]} + carry. They fit in 2 bits because the maximum sum is 3·2^WIDTH−3.
- RUN→DONE after the NCH-th chunk, together with the top-bit write. out_valid is registered and rises on the same edge.
- DONE: out_valid=1. result and reduced are held stable until out_ready. DONE→IDLE on out_valid & out_ready.
- The result register keeps its last value in IDLE and is overwritten chunk by chunk in RUN.
- rst at any time:
  - state=IDLE, out_valid=0, result=0, reduced=0, carry=0, borrow=0, k=0.
  - An in-flight operation is discarded with no output.
- in_valid while busy is not accepted. The upstream must hold its operands.

## Timing
- The accept edge is E0. Chunk k is written at edge E(k+1).
- out_valid is high starting NCH cycles after E0: 4 cycles for 256/64.
- Minimum spacing between accepts is NCH+2 cycles: RUN cycles, DONE handshake, then IDLE.
- The critical path is one CHUNK-bit adder, plus one CHUNK-bit subtractor when the macro is set.
- Reset values: in_ready=0 while rst=1, and 1 on the first cycle after rst drops. out_valid=0, result=0, reduced=0.

## Configuration
- Macro: CSA_RESOLVE_MODRED_EN.
- Defined:
  - A parallel borrow chain computes D = R − mod_p (mod_p zero-extended to WIDTH+2), chunk by chunk in the same RUN cycles.
  - The top-bit cycle finishes the borrow.
  - On entry to DONE: if the final borrow is 0, result=D and reduced=1; otherwise result=R and reduced=0.
  - There is one subtraction only. The result is fully reduced only when R < 2·mod_p.
  - Latency is unchanged.
- Undefined: no subtract logic, mod_p is unused, reduced is tied to 0.

## Structure
- Package csa_resolve_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the default WIDTH and CHUNK;
  - the NCH and index-width helper constants;
  - the SM2 prime as a reference constant for benches.
- Sub-module cpa_chunk: CHUNK-bit add with carry in/out, plus a CHUNK-bit subtract with borrow in/out under the macro. It is instantiated once and time-multiplexed over the chunks.

## Test plan
- Zero operands:
  - Stimulus: cin_vec=0, s_vec=0.
  - Response: result=0, out_valid exactly 4 cycles after the accept edge, in_ready=0 throughout.
- Full carry ripple:
  - Stimulus: s_vec=2^256−1, cin_vec=2.
  - Response: result=2^256+1, carry propagated across all 4 chunks.
- Maximum operands:
  - Stimulus: cin_vec=2^257−2, s_vec=2^256−1.
  - Response: result=3·2^256−3, with bits 257:256=2'b10 and the low bits 0xFF…FD.
- Backpressure:
  - Stimulus: out_ready held 0 for 5 cycles in DONE.
  - Response: result and out_valid are stable. in_ready=0. A new in_valid is not accepted until one cycle after the handshake.
- Reset mid-operation:
  - Stimulus: rst pulsed at the second RUN cycle.
  - Response: out_valid never rises, result=0, in_ready=1 on the cycle after rst drops. The next operation completes correctly.
- Modulus reduction (macro defined, mod_p = SM2 prime 0xFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF):
  - s_vec=p, cin_vec=0: result=0, reduced=1.
  - s_vec=p−1, cin_vec=0: result=p−1, reduced=0.

Source files
------------

// File: rtl/csa_resolve_pkg.sv
// csa_resolve_pkg: shared types, default geometry and reference constants for csa_resolve
package csa_resolve_pkg;
  localparam int WIDTH_D = 256;
  localparam int CHUNK_D = 64;
  localparam int NCH_D = WIDTH_D / CHUNK_D;
  localparam logic [255:0] SM2_P =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int KW_D = idx_w(NCH_D);
endpackage

// File: rtl/csa_resolve_cpa_chunk.sv
// cpa_chunk: one CHUNK-bit add slice; with CSA_RESOLVE_MODRED_EN also subtracts the modulus slice
module cpa_chunk
  import csa_resolve_pkg::*;
#(
  parameter int CHUNK = CHUNK_D
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
`ifdef CSA_RESOLVE_MODRED_EN
  ,
  input  logic [CHUNK-1:0] m,
  input  logic             bi,
  output logic [CHUNK-1:0] d,
  output logic             bo
`endif
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
`ifdef CSA_RESOLVE_MODRED_EN
  assign {bo, d} = {1'b0, s} - {1'b0, m} - {{CHUNK{1'b0}}, bi};
`endif
endmodule

// File: rtl/csa_resolve.sv
// csa_resolve: chunked carry-save to binary resolver; CSA_RESOLVE_MODRED_EN adds one conditional modulus subtraction
module csa_resolve
  import csa_resolve_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int CHUNK = CHUNK_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   cin_vec,
  input  logic [WIDTH-1:0] s_vec,
  input  logic [WIDTH-1:0] mod_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] result,
  output logic             reduced
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int KW = idx_w(NCH);

  state_t state, state_n;
  logic [KW-1:0] k;
  logic [WIDTH:0] cin_r;
  logic [WIDTH-1:0] s_r;
  logic carry, co, last, acc;
  logic [CHUNK-1:0] sum;
  logic [1:0] top;
  logic unused_bit;

  assign unused_bit = cin_vec[0];
  assign in_ready = state == IDLE && !rst;
  assign acc = in_valid && in_ready;
  assign last = k == KW'(NCH - 1);
  // top two bits absorb the carry-vector MSB and the final chunk carry
  assign top = {1'b0, cin_r[WIDTH]} + {1'b0, co};

  always_comb begin
    state_n = state;
    state_n = (state == IDLE && acc) ? RUN :
              (state == RUN && last) ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
  end

`ifdef CSA_RESOLVE_MODRED_EN
  logic [WIDTH-1:0] mod_r, dres, dfull;
  logic borrow, bo;
  logic [CHUNK-1:0] dif;
  logic [2:0] dtop;

  assign dtop = {1'b0, top} - {2'b0, bo};

  always_comb begin
    dfull = dres;
    dfull[k*CHUNK +: CHUNK] = dif;
  end

  cpa_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a(cin_r[k*CHUNK +: CHUNK]), .b(s_r[k*CHUNK +: CHUNK]), .ci(carry), .s(sum), .co(co),
    .m(mod_r[k*CHUNK +: CHUNK]), .bi(borrow), .d(dif), .bo(bo)
  );
`else
  logic unused_mod;

  assign unused_mod = ^mod_p;
  assign reduced = 1'b0;

  cpa_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a(cin_r[k*CHUNK +: CHUNK]), .b(s_r[k*CHUNK +: CHUNK]), .ci(carry), .s(sum), .co(co)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      result <= '0;
      carry <= 1'b0;
      k <= '0;
`ifdef CSA_RESOLVE_MODRED_EN
      borrow <= 1'b0;
      reduced <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (acc) begin
        cin_r <= {cin_vec[WIDTH:1], 1'b0};
        s_r <= s_vec;
        carry <= 1'b0;
        k <= '0;
`ifdef CSA_RESOLVE_MODRED_EN
        mod_r <= mod_p;
        borrow <= 1'b0;
`endif
      end
      if (state == RUN) begin
        result[k*CHUNK +: CHUNK] <= sum;
        carry <= co;
        k <= k + 1'b1;
`ifdef CSA_RESOLVE_MODRED_EN
        dres[k*CHUNK +: CHUNK] <= dif;
        borrow <= bo;
`endif
        if (last) begin
          out_valid <= 1'b1;
`ifdef CSA_RESOLVE_MODRED_EN
          reduced <= !dtop[2];
          if (!dtop[2]) result <= {dtop[1:0], dfull};
          else result[WIDTH+1:WIDTH] <= top;
`else
          result[WIDTH+1:WIDTH] <= top;
`endif
        end
      end
      if (state == DONE && out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_csa_resolve.sv
// tb_csa_resolve: scoreboard bench for csa_resolve (honours CSA_RESOLVE_MODRED_EN)
module tb_csa_resolve;
  import csa_resolve_pkg::*;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, reduced;
  logic [256:0] cin_vec = '0;
  logic [255:0] s_vec = '0, mod_p = '0;
  logic [257:0] result;
  int passed = 0, total = 0, cyc = 0, acc_cyc = 0;
  logic [258:0] sbq[$];
  logic prev_ov = 1'b0;

  localparam logic [257:0] ONE = 258'd1;
  localparam logic [255:0] ONES = {256{1'b1}};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  csa_resolve dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .cin_vec(cin_vec), .s_vec(s_vec), .mod_p(mod_p),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .reduced(reduced)
  );

  task automatic chk(input string name, input logic [257:0] act, input logic [257:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b want %b", name, act, exp);
  endtask

  function automatic logic [258:0] expect_of(input logic [257:0] r, input logic [255:0] m);
`ifdef CSA_RESOLVE_MODRED_EN
    return r >= {2'b0, m} ? {1'b1, r - {2'b0, m}} : {1'b0, r};
`else
    return {1'b0, r};
`endif
  endfunction

  always @(negedge clk) begin
    logic [258:0] e;
    if (out_valid && !prev_ov) chk("latency", 258'(cyc - acc_cyc), 258'(NCH_D));
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL unexpected_out: got result %h want no output", result);
      end else begin
        e = sbq.pop_front();
        chk("result", result, e[257:0]);
        chk1("reduced", reduced, e[258]);
      end
    end
    prev_ov = out_valid;
  end

  task automatic send(input logic [256:0] c, input logic [255:0] s, input logic [257:0] r, input bit push);
    int n = 0;
    @(posedge clk); #2;
    while (!in_ready && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    chk1("accept_wait", in_ready, 1'b1);
    in_valid = 1'b1;
    cin_vec = c;
    s_vec = s;
    mod_p = SM2_P;
    if (push) sbq.push_back(expect_of(r, SM2_P));
    @(posedge clk); #1 acc_cyc = cyc;
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 258'(sbq.size()), 258'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [258:0] bp_exp;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 258'd0);
    chk1("rst_reduced", reduced, 1'b0);
    @(posedge clk); #2 rst = 1'b0;
    #1 chk1("in_ready_after_rst", in_ready, 1'b1);
    send(257'd0, 256'd0, 258'd0, 1);
    repeat (4) begin
      @(negedge clk);
      chk1("busy_in_ready", in_ready, 1'b0);
    end
    send(257'd2, ONES, (ONE << 256) + ONE, 1);
    send({1'b1, {255{1'b1}}, 1'b0}, ONES, 258'd3 * (ONE << 256) - 258'd3, 1);
    send(257'd1, 256'd5, 258'd5, 1);
    send(257'd1 << 256, ONES, (ONE << 257) - ONE, 1);
    send(257'd2, (256'd1 << 64) - 256'd1, (ONE << 64) + ONE, 1);
    send(257'd0, SM2_P, {2'b0, SM2_P}, 1);
    send(257'd0, SM2_P - 256'd1, {2'b0, SM2_P - 256'd1}, 1);
    drain();
    @(posedge clk); #2 out_ready = 1'b0;
    bp_exp = expect_of(258'h1244, SM2_P);
    send(257'h10, 256'h1234, 258'h1244, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk1("bp_valid_rise", out_valid, 1'b1);
    #1;
    in_valid = 1'b1;
    cin_vec = 257'd0;
    s_vec = 256'd1;
    sbq.push_back(expect_of(258'd1, SM2_P));
    repeat (5) begin
      @(negedge clk);
      chk1("bp_valid", out_valid, 1'b1);
      chk("bp_result", result, bp_exp[257:0]);
      chk1("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #2 out_ready = 1'b1;
    @(posedge clk); #1;
    chk1("bp_in_ready_after", in_ready, 1'b1);
    @(posedge clk); #1 acc_cyc = cyc;
    #1 in_valid = 1'b0;
    drain();
    send(257'd0, ONES, 258'd0, 0);
    @(posedge clk); #2 rst = 1'b1;
    #1 chk1("rst_mid_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    chk("rst_mid_result", result, 258'd0);
    chk1("rst_mid_valid", out_valid, 1'b0);
    #1 rst = 1'b0;
    #1 chk1("rst_mid_ready_after", in_ready, 1'b1);
    repeat (8) @(negedge clk);
    chk1("rst_mid_no_out", out_valid, 1'b0);
    send(257'd8, 256'd7, 258'd15, 1);
    drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
